cache_port_arbiter: RTL and testbench

//  Shares the single cache request/response port between two requesters: P0 = instruction fetch, P1 = data load/store.

---
 rtl/cache_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_cache_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_port_arbiter.sv
// ============================================================================
// cache_port_arbiter
//
// Shares one cache request/response port between two requesters:
//   P0 = instruction fetch, P1 = data load/store.
// Exactly one transaction is in flight at a time. Each transaction moves
// through IDLE -> ISSUE -> WAIT -> RETURN -> IDLE. The cache response is
// forwarded only to the requester that was granted.
//
// Configuration macro:
//   CACHE_ARB_FIXED_PRIO_EN  defined   : P0 always wins when both are valid
//                            undefined : round-robin on a tie (default)
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   Pn_REQ_VALID/ADDR/WE/DATA requester n request (n = 0, 1)
//   Pn_REQ_READY             request accepted this cycle (combinational, IDLE only)
//   Pn_RESP_VALID/DATA       response to requester n (data is 0 when not valid)
//   Pn_RESP_READY            requester n takes the response
//   CACHE_ADDR_VALID/ADDR    cache RECEIVE_ADDR_VALID / RECEIVE_ADDR
//   CACHE_DATA_VALID/DATA    cache RECEIVE_DATA_VALID (write flag) / RECEIVE_DATA
//   CACHE_READY              cache RECEIVE_READY
//   CACHE_RESP_VALID/DATA    cache SEND_VALID / SEND_DATA
//   CACHE_RESP_READY         cache SEND_READY
// ============================================================================
module cache_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,

    input  logic                  P0_REQ_VALID,
    input  logic [ADDR_WIDTH-1:0] P0_REQ_ADDR,
    input  logic                  P0_REQ_WE,
    input  logic [DATA_WIDTH-1:0] P0_REQ_DATA,
    output logic                  P0_REQ_READY,
    output logic                  P0_RESP_VALID,
    output logic [DATA_WIDTH-1:0] P0_RESP_DATA,
    input  logic                  P0_RESP_READY,

    input  logic                  P1_REQ_VALID,
    input  logic [ADDR_WIDTH-1:0] P1_REQ_ADDR,
    input  logic                  P1_REQ_WE,
    input  logic [DATA_WIDTH-1:0] P1_REQ_DATA,
    output logic                  P1_REQ_READY,
    output logic                  P1_RESP_VALID,
    output logic [DATA_WIDTH-1:0] P1_RESP_DATA,
    input  logic                  P1_RESP_READY,

    output logic                  CACHE_ADDR_VALID,
    output logic [ADDR_WIDTH-1:0] CACHE_ADDR,
    output logic                  CACHE_DATA_VALID,
    output logic [DATA_WIDTH-1:0] CACHE_DATA,
    input  logic                  CACHE_READY,
    input  logic                  CACHE_RESP_VALID,
    input  logic [DATA_WIDTH-1:0] CACHE_RESP_DATA,
    output logic                  CACHE_RESP_READY
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_RETURN = 2'd3
    } state_t;

    state_t                  state;
    logic                    grant;          // 0 = P0, 1 = P1
`ifndef CACHE_ARB_FIXED_PRIO_EN
    logic                    last_grant;     // port served by the previous transaction
`endif
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH-1:0]   resp_data_q;
    logic                    cache_addr_valid_q;
    logic                    cache_data_valid_q;
    logic                    cache_resp_ready_q;
    logic                    p0_resp_valid_q;
    logic                    p1_resp_valid_q;

    logic                    req_any;
    logic                    req_win;
    logic                    req_accept;
    logic                    resp_taken;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: the default assignment first means every path through this
        // block assigns req_win, so no latch is inferred.
        req_win = 1'b0;
        if (P0_REQ_VALID && P1_REQ_VALID) begin
`ifdef CACHE_ARB_FIXED_PRIO_EN
            req_win = 1'b0;
`else
            req_win = ~last_grant;
`endif
        end else if (P1_REQ_VALID) begin
            req_win = 1'b1;
        end
    end

    assign req_any    = P0_REQ_VALID | P1_REQ_VALID;
    // READY is suppressed while RST is high: the request would not be latched
    // that cycle, so acknowledging it would silently drop it.
    assign req_accept = (state == S_IDLE) && req_any && !RST;
    assign resp_taken = grant ? P1_RESP_READY : P0_RESP_READY;

    assign P0_REQ_READY     = req_accept && !req_win;
    assign P1_REQ_READY     = req_accept &&  req_win;

    assign P0_RESP_VALID    = p0_resp_valid_q;
    assign P1_RESP_VALID    = p1_resp_valid_q;
    assign P0_RESP_DATA     = p0_resp_valid_q ? resp_data_q : '0;
    assign P1_RESP_DATA     = p1_resp_valid_q ? resp_data_q : '0;

    assign CACHE_ADDR_VALID = cache_addr_valid_q;
    assign CACHE_DATA_VALID = cache_data_valid_q;
    assign CACHE_ADDR       = addr_q;
    assign CACHE_DATA       = data_q;
    assign CACHE_RESP_READY = cache_resp_ready_q;

    // ------------------------------------------------------------------------
    // Transaction FSM with registered handshake outputs
    // ------------------------------------------------------------------------
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state              <= S_IDLE;
            grant              <= 1'b0;
`ifndef CACHE_ARB_FIXED_PRIO_EN
            last_grant         <= 1'b1;
`endif
            addr_q             <= '0;
            data_q             <= '0;
            resp_data_q        <= '0;
            cache_addr_valid_q <= 1'b0;
            cache_data_valid_q <= 1'b0;
            cache_resp_ready_q <= 1'b0;
            p0_resp_valid_q    <= 1'b0;
            p1_resp_valid_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_any) begin
                        grant              <= req_win;
                        addr_q             <= req_win ? P1_REQ_ADDR : P0_REQ_ADDR;
                        data_q             <= req_win ? P1_REQ_DATA : P0_REQ_DATA;
                        cache_addr_valid_q <= 1'b1;
                        cache_data_valid_q <= req_win ? P1_REQ_WE : P0_REQ_WE;
                        state              <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // CACHE_ADDR_VALID is always high here, so CACHE_READY
                    // alone completes the address handshake.
                    if (CACHE_READY) begin
                        cache_addr_valid_q <= 1'b0;
                        cache_data_valid_q <= 1'b0;
                        cache_resp_ready_q <= 1'b1;
                        state              <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (CACHE_RESP_VALID) begin
                        resp_data_q        <= CACHE_RESP_DATA;
                        cache_resp_ready_q <= 1'b0;
                        p0_resp_valid_q    <= ~grant;
                        p1_resp_valid_q    <=  grant;
                        state              <= S_RETURN;
                    end
                end
                S_RETURN: begin
                    if (resp_taken) begin
                        p0_resp_valid_q <= 1'b0;
                        p1_resp_valid_q <= 1'b0;
`ifndef CACHE_ARB_FIXED_PRIO_EN
                        last_grant      <= grant;
`endif
                        state           <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// ============================================================================
// tb_cache_port_arbiter
//
// Directed bench for cache_port_arbiter. The bench plays both requesters and
// the cache. Inputs are driven and outputs sampled on the falling edge of CLK,
// half a cycle away from the rising edge the DUT uses.
// ============================================================================
module tb_cache_port_arbiter;

    localparam logic [31:0] WR_ACK = 32'h0000_600D;  // cache's SEND_DATA for writes

    logic        CLK;
    logic        RST;
    logic        P0_REQ_VALID, P0_REQ_WE, P0_REQ_READY, P0_RESP_VALID, P0_RESP_READY;
    logic [31:0] P0_REQ_ADDR, P0_REQ_DATA, P0_RESP_DATA;
    logic        P1_REQ_VALID, P1_REQ_WE, P1_REQ_READY, P1_RESP_VALID, P1_RESP_READY;
    logic [31:0] P1_REQ_ADDR, P1_REQ_DATA, P1_RESP_DATA;
    logic        CACHE_ADDR_VALID, CACHE_DATA_VALID, CACHE_READY;
    logic        CACHE_RESP_VALID, CACHE_RESP_READY;
    logic [31:0] CACHE_ADDR, CACHE_DATA, CACHE_RESP_DATA;

    int n_vec = 0;
    int n_err = 0;

    // Backing store of the cache stand-in.
    logic [31:0] mem [logic [31:0]];

    cache_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .P0_REQ_VALID     (P0_REQ_VALID),
        .P0_REQ_ADDR      (P0_REQ_ADDR),
        .P0_REQ_WE        (P0_REQ_WE),
        .P0_REQ_DATA      (P0_REQ_DATA),
        .P0_REQ_READY     (P0_REQ_READY),
        .P0_RESP_VALID    (P0_RESP_VALID),
        .P0_RESP_DATA     (P0_RESP_DATA),
        .P0_RESP_READY    (P0_RESP_READY),
        .P1_REQ_VALID     (P1_REQ_VALID),
        .P1_REQ_ADDR      (P1_REQ_ADDR),
        .P1_REQ_WE        (P1_REQ_WE),
        .P1_REQ_DATA      (P1_REQ_DATA),
        .P1_REQ_READY     (P1_REQ_READY),
        .P1_RESP_VALID    (P1_RESP_VALID),
        .P1_RESP_DATA     (P1_RESP_DATA),
        .P1_RESP_READY    (P1_RESP_READY),
        .CACHE_ADDR_VALID (CACHE_ADDR_VALID),
        .CACHE_ADDR       (CACHE_ADDR),
        .CACHE_DATA_VALID (CACHE_DATA_VALID),
        .CACHE_DATA       (CACHE_DATA),
        .CACHE_READY      (CACHE_READY),
        .CACHE_RESP_VALID (CACHE_RESP_VALID),
        .CACHE_RESP_DATA  (CACHE_RESP_DATA),
        .CACHE_RESP_READY (CACHE_RESP_READY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, vectors=%0d miscompares=%0d", n_vec, n_err);
        $fatal(1, "time limit");
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int port, input logic v, input logic we,
                           input logic [31:0] addr, input logic [31:0] data);
        if (port == 0) begin
            P0_REQ_VALID = v; P0_REQ_WE = we; P0_REQ_ADDR = addr; P0_REQ_DATA = data;
        end else begin
            P1_REQ_VALID = v; P1_REQ_WE = we; P1_REQ_ADDR = addr; P1_REQ_DATA = data;
        end
    endtask

    task automatic set_resp_ready(input int port, input logic v);
        if (port == 0) P0_RESP_READY = v;
        else           P1_RESP_READY = v;
    endtask

    function automatic logic req_ready(input int port);
        return (port == 0) ? P0_REQ_READY : P1_REQ_READY;
    endfunction

    function automatic logic resp_valid(input int port);
        return (port == 0) ? P0_RESP_VALID : P1_RESP_VALID;
    endfunction

    function automatic logic [31:0] resp_data(input int port);
        return (port == 0) ? P0_RESP_DATA : P1_RESP_DATA;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_flags"}, {57'd0, P0_REQ_READY, P1_REQ_READY, P0_RESP_VALID, P1_RESP_VALID,
                                CACHE_ADDR_VALID, CACHE_DATA_VALID, CACHE_RESP_READY}, 64'd0);
        check({tag, "_cache_bus"}, {CACHE_ADDR, CACHE_DATA}, 64'd0);
        check({tag, "_resp_data"}, {P0_RESP_DATA, P1_RESP_DATA}, 64'd0);
    endtask

    // One full transaction from IDLE back to IDLE. While stalled in ISSUE or
    // RETURN the other requester raises VALID and must not be accepted.
    task automatic txn(input int port, input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] exp_resp,
                       input int issue_stall, input int ret_stall);
        int          other;
        logic [31:0] rd;
        other = 1 - port;

        set_req(port, 1'b1, we, addr, data);
        #1;
        check("accept_ready", {63'd0, req_ready(port)}, 64'd1);
        check("accept_other_ready", {63'd0, req_ready(other)}, 64'd0);
        @(negedge CLK);
        set_req(port, 1'b0, 1'b0, 32'd0, 32'd0);

        // ISSUE
        check("issue_addr_valid", {63'd0, CACHE_ADDR_VALID}, 64'd1);
        check("issue_addr", {32'd0, CACHE_ADDR}, {32'd0, addr});
        check("issue_we", {63'd0, CACHE_DATA_VALID}, {63'd0, we});
        check("issue_data", {32'd0, CACHE_DATA}, {32'd0, data});
        for (int i = 0; i < issue_stall; i++) begin
            set_req(other, 1'b1, 1'b0, 32'h0000_0F00, 32'd0);
            #1;
            check("stall_req_ready", {62'd0, P0_REQ_READY, P1_REQ_READY}, 64'd0);
            @(negedge CLK);
            check("stall_addr_valid", {63'd0, CACHE_ADDR_VALID}, 64'd1);
            check("stall_addr", {32'd0, CACHE_ADDR}, {32'd0, addr});
            check("stall_data", {32'd0, CACHE_DATA}, {32'd0, data});
        end
        set_req(other, 1'b0, 1'b0, 32'd0, 32'd0);

        // Cache stand-in: writes store and return WR_ACK, reads return the store.
        if (CACHE_DATA_VALID) begin
            mem[CACHE_ADDR] = CACHE_DATA;
            rd = WR_ACK;
        end else begin
            rd = mem.exists(CACHE_ADDR) ? mem[CACHE_ADDR] : 32'd0;
        end
        CACHE_READY = 1'b1;
        @(negedge CLK);
        CACHE_READY = 1'b0;

        // WAIT
        check("wait_resp_ready", {63'd0, CACHE_RESP_READY}, 64'd1);
        check("wait_addr_valid", {63'd0, CACHE_ADDR_VALID}, 64'd0);
        CACHE_RESP_VALID = 1'b1;
        CACHE_RESP_DATA  = rd;
        @(negedge CLK);
        CACHE_RESP_VALID = 1'b0;
        CACHE_RESP_DATA  = 32'd0;

        // RETURN
        for (int i = 0; i <= ret_stall; i++) begin
            check("ret_valid", {63'd0, resp_valid(port)}, 64'd1);
            check("ret_data", {32'd0, resp_data(port)}, {32'd0, exp_resp});
            check("ret_other_valid", {63'd0, resp_valid(other)}, 64'd0);
            check("ret_other_data", {32'd0, resp_data(other)}, 64'd0);
            check("ret_cache_resp_ready", {63'd0, CACHE_RESP_READY}, 64'd0);
            if (i < ret_stall) begin
                set_req(other, 1'b1, 1'b0, 32'h0000_0F00, 32'd0);
                #1;
                check("ret_stall_req_ready", {62'd0, P0_REQ_READY, P1_REQ_READY}, 64'd0);
                @(negedge CLK);
            end
        end
        set_req(other, 1'b0, 1'b0, 32'd0, 32'd0);
        set_resp_ready(port, 1'b1);
        @(negedge CLK);
        set_resp_ready(port, 1'b0);
        check("done_resp_valid", {62'd0, P0_RESP_VALID, P1_RESP_VALID}, 64'd0);
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        int          cnt0;
        int          cnt1;
        int          g_exp;
        logic [31:0] exp_addr;

        RST = 1'b1;
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        P0_RESP_READY = 1'b0; P1_RESP_READY = 1'b0;
        CACHE_READY = 1'b0; CACHE_RESP_VALID = 1'b0; CACHE_RESP_DATA = 32'd0;

        // 1. Reset held 10 cycles; a request during reset is not acknowledged.
        repeat (10) @(negedge CLK);
        P0_REQ_VALID = 1'b1;
        #1;
        check_reset_outputs("reset");
        P0_REQ_VALID = 1'b0;
        RST = 1'b0;

        // 2. P0 write then read back; P1 never sees a response.
        txn(0, 1'b1, 32'h0000_1040, 32'hDEAD_BEEF, WR_ACK, 0, 0);
        txn(0, 1'b0, 32'h0000_1040, 32'd0, 32'hDEAD_BEEF, 0, 0);

        // 3. Both requesters continuously valid, 6 requests each.
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        cnt0 = 0;
        cnt1 = 0;
        set_req(0, 1'b1, 1'b0, 32'h0000_2000, 32'd0);
        set_req(1, 1'b1, 1'b0, 32'h0000_3000, 32'd0);
        for (int t = 0; t < 12; t++) begin
`ifdef CACHE_ARB_FIXED_PRIO_EN
            g_exp = (t < 6) ? 0 : 1;
`else
            g_exp = t % 2;
`endif
            #1;
            check("rr_p0_ready", {63'd0, P0_REQ_READY}, {63'd0, g_exp == 0});
            check("rr_p1_ready", {63'd0, P1_REQ_READY}, {63'd0, g_exp == 1});
            exp_addr = (g_exp == 0) ? 32'h0000_2000 + 32'(cnt0 * 4)
                                    : 32'h0000_3000 + 32'(cnt1 * 4);
            @(negedge CLK);
            // The granted requester moves on to its next request.
            if (g_exp == 0) begin
                cnt0++;
                if (cnt0 < 6) P0_REQ_ADDR = 32'h0000_2000 + 32'(cnt0 * 4);
                else          P0_REQ_VALID = 1'b0;
            end else begin
                cnt1++;
                if (cnt1 < 6) P1_REQ_ADDR = 32'h0000_3000 + 32'(cnt1 * 4);
                else          P1_REQ_VALID = 1'b0;
            end
            check("rr_cache_addr", {32'd0, CACHE_ADDR}, {32'd0, exp_addr});
            CACHE_READY = 1'b1;
            @(negedge CLK);
            CACHE_READY = 1'b0;
            CACHE_RESP_VALID = 1'b1;
            CACHE_RESP_DATA  = exp_addr ^ 32'hA5A5_0000;
            @(negedge CLK);
            CACHE_RESP_VALID = 1'b0;
            CACHE_RESP_DATA  = 32'd0;
            check("rr_resp_valid", {63'd0, resp_valid(g_exp)}, 64'd1);
            check("rr_other_resp_valid", {63'd0, resp_valid(1 - g_exp)}, 64'd0);
            check("rr_resp_data", {32'd0, resp_data(g_exp)}, {32'd0, exp_addr ^ 32'hA5A5_0000});
            set_resp_ready(g_exp, 1'b1);
            @(negedge CLK);
            set_resp_ready(g_exp, 1'b0);
        end

        // 4. Cache stalls 20 cycles in ISSUE while P1 keeps asking.
        txn(0, 1'b0, 32'h0000_1040, 32'd0, 32'hDEAD_BEEF, 20, 0);

        // 5. P1 holds RESP_READY low 15 cycles while P0 keeps asking; P0 then goes.
        txn(1, 1'b1, 32'h0000_1044, 32'h1234_5678, WR_ACK, 0, 15);
        txn(0, 1'b0, 32'h0000_1044, 32'd0, 32'h1234_5678, 0, 0);

        // 6. Reset pulsed for one cycle while in WAIT.
        set_req(1, 1'b1, 1'b0, 32'h0000_1044, 32'd0);
        #1;
        check("w6_accept", {63'd0, P1_REQ_READY}, 64'd1);
        @(negedge CLK);
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        CACHE_READY = 1'b1;
        @(negedge CLK);
        CACHE_READY = 1'b0;
        check("w6_in_wait", {63'd0, CACHE_RESP_READY}, 64'd1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check_reset_outputs("w6_after_rst");
        // A late cache response arriving in IDLE is neither taken nor forwarded.
        CACHE_RESP_VALID = 1'b1;
        CACHE_RESP_DATA  = 32'h0000_0BAD;
        #1;
        check("w6_stale_resp_ready", {63'd0, CACHE_RESP_READY}, 64'd0);
        @(negedge CLK);
        CACHE_RESP_VALID = 1'b0;
        CACHE_RESP_DATA  = 32'd0;
        check("w6_stale_resp_valid", {62'd0, P0_RESP_VALID, P1_RESP_VALID}, 64'd0);
        txn(1, 1'b0, 32'h0000_1040, 32'd0, 32'hDEAD_BEEF, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
